// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory timeout and traps.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_control_unit #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               branch,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic               halted,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WLIM =
        WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     op_q, op_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [1:0]     err_q, err_d;
    logic [2:0]     aop;
    logic           wait_hit;

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

    assign wait_hit = TO_EN && (wait_q == WLIM) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Wait counter defaults to zero, so every entry into FETCH/MEM starts fresh.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = '0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                    op_d    = opcode;
                end else if (wait_hit) begin
                    state_d = S_ERROR;
                    err_d   = 2'b10;
                end else if (TO_EN) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (!is_legal(opcode)) begin
                    state_d = S_ERROR;
                    err_d   = 2'b01;
                end else if (opcode == OP_FENCE) begin
                    state_d = S_FETCH;
                end else if (opcode == OP_SYSTEM) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH)
                    state_d = S_FETCH;
                else if (op_q == OP_LOAD || op_q == OP_STORE)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
                end else if (wait_hit) begin
                    state_d = S_ERROR;
                    err_d   = 2'b10;
                end else if (TO_EN) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        aop        = 3'b000;
        reg_write  = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        err_code   = err_q;
        unique case (state_q)
            S_IDLE: err_code = 2'b00;
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_DECODE: pc_write = (op_q == OP_FENCE);
            S_EXEC: begin
                unique case (op_q)
                    OP_REG:    aop = 3'b010;
                    OP_IMM:    aop = 3'b011;
                    OP_BRANCH: aop = 3'b001;
                    OP_LUI:    aop = 3'b101;
                    default:   aop = 3'b000;
                endcase
                alu_src  = !(op_q == OP_REG || op_q == OP_BRANCH);
                branch   = (op_q == OP_BRANCH);
                pc_write = (op_q == OP_BRANCH);
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q == OP_STORE);
                pc_write  = (op_q == OP_STORE) && mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (op_q == OP_LOAD);
                branch     = (op_q == OP_JAL || op_q == OP_JALR);
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: err = 1'b1;
            default: err_code = 2'b00;
        endcase
    end

    assign alu_op = ALUOP_W'(aop);

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // pc_write is never high in HALT/ERROR, so the count freezes there.
    always_comb begin
        cnt_d = cnt_q;
        if (pc_write)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit (MEM_TIMEOUT=4).
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       br;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       as;
        logic [2:0] aop;
        logic       rw;
        logic       h;
        logic       e;
        logic [1:0] ec;
    } ov_t;

    localparam ov_t Z   = '0;
    localparam ov_t F0  = '{mr: 1'b1, default: '0};
    localparam ov_t F1  = '{mr: 1'b1, irw: 1'b1, default: '0};
    localparam ov_t DFN = '{pcw: 1'b1, default: '0};
    localparam ov_t XR  = '{aop: 3'b010, default: '0};
    localparam ov_t XI  = '{as: 1'b1, aop: 3'b011, default: '0};
    localparam ov_t XB  = '{br: 1'b1, pcw: 1'b1, aop: 3'b001, default: '0};
    localparam ov_t XLU = '{as: 1'b1, aop: 3'b101, default: '0};
    localparam ov_t XA  = '{as: 1'b1, default: '0};
    localparam ov_t ML  = '{mr: 1'b1, as: 1'b1, default: '0};
    localparam ov_t MS1 = '{mw: 1'b1, as: 1'b1, pcw: 1'b1, default: '0};
    localparam ov_t WR  = '{rw: 1'b1, pcw: 1'b1, default: '0};
    localparam ov_t WL  = '{rw: 1'b1, pcw: 1'b1, m2r: 1'b1, default: '0};
    localparam ov_t WJ  = '{rw: 1'b1, pcw: 1'b1, br: 1'b1, default: '0};
    localparam ov_t HLT = '{h: 1'b1, default: '0};
    localparam ov_t ERI = '{e: 1'b1, ec: 2'b01, default: '0};
    localparam ov_t ERT = '{e: 1'b1, ec: 2'b10, default: '0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_ready = 1'b0;
    logic [4:0]  opcode = 5'b00000;
    logic        pc_write, ir_write, branch, mem_read, mem_write;
    logic        mem_to_reg, alu_src, reg_write, halted, err;
    logic [2:0]  alu_op;
    logic [1:0]  err_code;
    logic [31:0] retire_cnt;

    multicycle_control_unit #(
        .ALUOP_W(3),
        .MEM_TIMEOUT(4),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .mem_ready(mem_ready),
        .pc_write(pc_write),
        .ir_write(ir_write),
        .branch(branch),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_to_reg(mem_to_reg),
        .alu_src(alu_src),
        .alu_op(alu_op),
        .reg_write(reg_write),
        .halted(halted),
        .err(err),
        .err_code(err_code),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    ov_t         act;
    ov_t         q[$];
    string       tq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned exp_ret = 0;

    always_comb act = {pc_write, ir_write, branch, mem_read, mem_write,
                       mem_to_reg, alu_src, alu_op, reg_write, halted,
                       err, err_code};

    task automatic check_out();
        ov_t   e;
        string t;
        e = q.pop_front();
        t = tq.pop_front();
        checks++;
        assert (act === e) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", t, act, e);
        end
    endtask

    task automatic chk_ret(input string t);
        logic [31:0] e;
`ifdef PERF_CNT_EN
        e = exp_ret;
`else
        e = 32'd0;
`endif
        checks++;
        assert (retire_cnt === e) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", t, retire_cnt, e);
        end
    endtask

    task automatic cyc(input logic mr, input ov_t e, input string t);
        mem_ready = mr;
        #1;
        q.push_back(e);
        tq.push_back(t);
        if (e.pcw)
            exp_ret++;
        check_out();
        @(negedge clk);
    endtask

    task automatic do_reset(input string t);
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        q.push_back(Z);
        tq.push_back(t);
        check_out();
        chk_ret({t, "_cnt"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset("rst0");
        cyc(1'b1, Z, "idle0");

        opcode = 5'b01100;
        cyc(1'b1, F1, "r_fetch");
        cyc(1'b1, Z, "r_dec");
        cyc(1'b1, XR, "r_exec");
        cyc(1'b1, WR, "r_wb");
        chk_ret("cnt_after_r");

        opcode = 5'b00000;
        cyc(1'b1, F1, "ld_fetch");
        cyc(1'b1, Z, "ld_dec");
        cyc(1'b1, XA, "ld_exec");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, ML, "ld_mem_wait");
        cyc(1'b1, ML, "ld_mem_ready");
        cyc(1'b1, WL, "ld_wb");

        opcode = 5'b01000;
        cyc(1'b1, F1, "st_fetch");
        cyc(1'b1, Z, "st_dec");
        cyc(1'b1, XA, "st_exec");
        cyc(1'b1, MS1, "st_mem");

        opcode = 5'b11000;
        cyc(1'b1, F1, "br_fetch");
        cyc(1'b1, Z, "br_dec");
        cyc(1'b1, XB, "br_exec");

        opcode = 5'b00100;
        cyc(1'b1, F1, "i_fetch");
        cyc(1'b1, Z, "i_dec");
        cyc(1'b1, XI, "i_exec");
        cyc(1'b1, WR, "i_wb");

        opcode = 5'b01101;
        cyc(1'b1, F1, "lui_fetch");
        cyc(1'b1, Z, "lui_dec");
        cyc(1'b1, XLU, "lui_exec");
        cyc(1'b1, WR, "lui_wb");

        opcode = 5'b11011;
        cyc(1'b1, F1, "jal_fetch");
        cyc(1'b1, Z, "jal_dec");
        cyc(1'b1, XA, "jal_exec");
        cyc(1'b1, WJ, "jal_wb");

        opcode = 5'b00011;
        cyc(1'b1, F1, "fence_fetch");
        cyc(1'b1, DFN, "fence_dec");
        chk_ret("cnt_mix");

        opcode = 5'b01111;
        cyc(1'b1, F1, "ill_fetch");
        cyc(1'b1, Z, "ill_dec");
        for (int i = 0; i < 20; i++)
            cyc(1'b0, ERI, "ill_err");
        do_reset("rst_ill");
        cyc(1'b1, Z, "idle_ill");

        opcode = 5'b01100;
        for (int i = 0; i < 4; i++)
            cyc(1'b0, F0, "to_fetch_wait");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, ERT, "to_err");
        do_reset("rst_to");
        cyc(1'b1, Z, "idle_to");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, F0, "rdy_fetch_wait");
        cyc(1'b1, F1, "rdy_limit");
        cyc(1'b1, Z, "rdy_dec");
        cyc(1'b1, XR, "rdy_exec");
        cyc(1'b1, WR, "rdy_wb");

        opcode = 5'b00000;
        cyc(1'b1, F1, "mto_fetch");
        cyc(1'b1, Z, "mto_dec");
        cyc(1'b1, XA, "mto_exec");
        for (int i = 0; i < 4; i++)
            cyc(1'b0, ML, "mto_mem_wait");
        cyc(1'b1, ERT, "mto_err");

        do_reset("rst_perf");
        cyc(1'b1, Z, "idle_perf");
        opcode = 5'b01100;
        cyc(1'b1, F1, "p_r_fetch");
        cyc(1'b1, Z, "p_r_dec");
        cyc(1'b1, XR, "p_r_exec");
        cyc(1'b1, WR, "p_r_wb");
        opcode = 5'b00011;
        cyc(1'b1, F1, "p_f_fetch");
        cyc(1'b1, DFN, "p_f_dec");
        opcode = 5'b11000;
        cyc(1'b1, F1, "p_b_fetch");
        cyc(1'b1, Z, "p_b_dec");
        cyc(1'b1, XB, "p_b_exec");
        opcode = 5'b11100;
        cyc(1'b1, F1, "ecall_fetch");
        cyc(1'b1, Z, "ecall_dec");
        cyc(1'b1, HLT, "halt0");
        chk_ret("cnt_halt");
        for (int i = 0; i < 5; i++)
            cyc(1'b1, HLT, "halt_hold");
        chk_ret("cnt_frozen");

        do_reset("rst_h");
        cyc(1'b1, Z, "idle_mid");
        cyc(1'b0, F0, "mid_fetch");
        do_reset("rst_mid");
        cyc(1'b1, Z, "idle_after_mid");
        cyc(1'b0, F0, "fetch_after_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
